demux: RTL and testbench
========================

# demux

Registered 1-to-3 stream demultiplexer: the distribution-side counterpart of the three-input registered priority mux. It accepts one WIDTH-bit word per cycle under a valid/ready handshake and routes it, by a 2-bit destination code, into one of three single-entry output registers, each drained by its own valid/ready consumer. Undeliverable words are discarded and counted. It sits between a single producer and three lane consumers.

## Interface
- WIDTH, 4, data width of input and all outputs
- clk  input  1  sole clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_data  input  WIDTH  input word
- in_dest  input  2  destination: 0→out1, 1→out2, 2→out3, 3→special (see Configuration)
- in_valid  input  1  in_data/in_dest valid
- in_ready  output  1  block can accept this cycle
- out1_data, out2_data, out3_data  output  WIDTH each  lane output registers
- out1_valid, out2_valid, out3_valid  output  1 each  lane register holds a word
- out1_ready, out2_ready, out3_ready  input  1 each  lane consumer accepts
- drop_cnt  output  8  count of discarded words, saturating

## Operation
- Input transfer: in_valid && in_ready at a rising edge.
- Lane k "free" = !outk_valid || outk_ready (empty, or being drained this cycle).
- in_ready (combinational): dest 0/1/2 → free of that lane only; dest 3 → per Configuration. Value irrelevant when in_valid=0 but must still follow the rule.
- Lane output transfer: outk_valid && outk_ready at a rising edge.
- Lane register update per edge, in priority order:
  - input transfer targets lane k → outk_data ← in_data, outk_valid ← 1 (simultaneous drain + load = back-to-back, no bubble);
  - else output transfer on lane k → outk_valid ← 0, outk_data holds;
  - else hold.
- outk_data stable while outk_valid=1 and outk_ready=0; outk_valid never drops without a transfer.
- Lanes independent: a stalled lane blocks only inputs addressed to it; in_ready low does not affect other lanes' draining.
- drop_cnt: +1 on each discarded input transfer; sticks at 255.
- Reset (any time, including mid-transfer): all outk_valid=0, outk_data=0, drop_cnt=0 immediately; in-flight words lost. First acceptance possible on first rising edge after rst_n deasserts.

## Timing
- Latency: word accepted at edge N is visible on outk_data with outk_valid=1 after edge N (1 cycle).
- Throughput: one word per cycle per lane when consumer holds ready=1; full rate into a single lane sustained.
- Combinational paths: outk_ready → in_ready, in_dest → in_ready. No combinational path from in_data/in_valid to any output.
- All outputs except in_ready are registers.

## Configuration
- DEMUX_BCAST_EN defined: dest 3 = broadcast. in_ready = free1 && free2 && free3; on transfer all three lanes load in_data the same edge. Never counted in drop_cnt (drop_cnt stays 0 in this build).
- DEMUX_BCAST_EN undefined: dest 3 = drop. in_ready = 1; word discarded, no lane changes, drop_cnt increments.

## Test plan
- Reset: assert rst_n=0 mid-stream with out2_valid=1 → all valid=0, data=0, drop_cnt=0 asynchronously; after release, in_dest=0, in_data=4'hA accepted → out1_valid=1, out1_data=A next cycle.
- Routing/latency: send 4'h1,4'h2,4'h3 to dest 0,1,2 on consecutive cycles, all ready=1 → each appears on its lane exactly one cycle after acceptance, other lanes unchanged.
- Backpressure: out3_ready=0, send 4'h5 then 4'h6 to dest 2 → 4'h5 held on out3, in_ready=0 for 4'h6; concurrently 4'h7 to dest 0 accepted; raise out3_ready → 4'h6 loaded same edge 4'h5 drains, no bubble.
- Full rate: 16 words 0..F to dest 1, out2_ready=1 → in_ready stays 1, out2_data sequence 0..F, out2_valid continuously high.
- Drop (macro off): 260 words with dest 3 → in_ready=1 throughout, no lane valid, drop_cnt=255.
- Broadcast (macro on): out1_ready=0 with out1 occupied, send 4'hC dest 3 → in_ready=0; release out1_ready → 4'hC on all three lanes next cycle, drop_cnt=0.

Source files
------------

// File: rtl/demux_if.sv
// demux_if: bundles the producer-side stream, the three lane streams and the
// drop counter of the demux. master = producer/consumers side (testbench),
// slave = demux side. Scalar clock and reset stay outside the interface.
interface demux_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_dest;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] out1_data;
    logic [WIDTH-1:0] out2_data;
    logic [WIDTH-1:0] out3_data;
    logic             out1_valid;
    logic             out2_valid;
    logic             out3_valid;
    logic             out1_ready;
    logic             out2_ready;
    logic             out3_ready;

    logic [7:0]       drop_cnt;

    modport master (
        output in_data, in_dest, in_valid,
        input  in_ready,
        input  out1_data, out2_data, out3_data,
        input  out1_valid, out2_valid, out3_valid,
        output out1_ready, out2_ready, out3_ready,
        input  drop_cnt
    );

    modport slave (
        input  in_data, in_dest, in_valid,
        output in_ready,
        output out1_data, out2_data, out3_data,
        output out1_valid, out2_valid, out3_valid,
        input  out1_ready, out2_ready, out3_ready,
        output drop_cnt
    );
endinterface

// File: rtl/demux.sv
// demux: registered 1-to-3 stream demultiplexer routing each word by in_dest
// into one of three single-entry lane registers; 1-cycle latency.
// Backpressure: in_ready follows only the addressed lane (free = empty or
// draining), so a stalled lane blocks only words aimed at it.
// Ports: clk, rst_n (async active-low), bus (demux_if.slave): in_* stream,
// out1..3_* lane streams, drop_cnt (saturating count of discarded words).
// Build option: DEMUX_BCAST_EN makes dest 3 a broadcast to all lanes;
// without it dest 3 words are discarded and counted.
module demux #(
    parameter int WIDTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    demux_if.slave bus
);

    logic [WIDTH-1:0] data_q [3];
    logic [2:0]       valid_q;
    logic [7:0]       drop_q;

    logic [2:0]       lane_rdy;
    logic [2:0]       free;
    logic [2:0]       load;
    logic             in_rdy;
    logic             xfer;
    logic             drop;

    // A lane can take a word if it is empty or its current word leaves this edge.
    assign lane_rdy = {bus.out3_ready, bus.out2_ready, bus.out1_ready};
    assign free     = ~valid_q | lane_rdy;

    always_comb begin
        in_rdy = 1'b0;
        case (bus.in_dest)
            2'd0: in_rdy = free[0];
            2'd1: in_rdy = free[1];
            2'd2: in_rdy = free[2];
            default: begin
`ifdef DEMUX_BCAST_EN
                in_rdy = &free;
`else
                in_rdy = 1'b1;
`endif
            end
        endcase
    end

    assign xfer = bus.in_valid && in_rdy;

    always_comb begin
        load = 3'b000;
        drop = 1'b0;
        if (xfer) begin
            case (bus.in_dest)
                2'd0: load = 3'b001;
                2'd1: load = 3'b010;
                2'd2: load = 3'b100;
                default: begin
`ifdef DEMUX_BCAST_EN
                    load = 3'b111;
`else
                    drop = 1'b1;
`endif
                end
            endcase
        end
    end

    // Load wins over drain so a lane can be refilled on the edge it empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                data_q[k] <= '0;
            end
            valid_q <= 3'b000;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (load[k]) begin
                    data_q[k]  <= bus.in_data;
                    valid_q[k] <= 1'b1;
                end else if (valid_q[k] && lane_rdy[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else if (drop && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out1_data  = data_q[0];
    assign bus.out2_data  = data_q[1];
    assign bus.out3_data  = data_q[2];
    assign bus.out1_valid = valid_q[0];
    assign bus.out2_valid = valid_q[1];
    assign bus.out3_valid = valid_q[2];
    assign bus.drop_cnt   = drop_q;

endmodule

// File: tb/tb_demux.sv
// tb_demux: directed and randomized stimulus for demux, checked against a
// queue-based reference model of the three lanes and the drop counter.
module tb_demux;

    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;

    demux_if #(.WIDTH(WIDTH)) bus ();

    demux #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each lane is a queue holding at most one word, plus
    // the last word written (data holds after a drain), and a drop count.
    logic [3:0] mq0[$];
    logic [3:0] mq1[$];
    logic [3:0] mq2[$];
    logic [3:0] mlast [3];
    int         mdrops;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int k);
        if (k == 0) return mq0.size();
        if (k == 1) return mq1.size();
        return mq2.size();
    endfunction

    task automatic qpop(input int k);
        if (k == 0) void'(mq0.pop_front());
        else if (k == 1) void'(mq1.pop_front());
        else void'(mq2.pop_front());
    endtask

    task automatic qpush(input int k, input logic [3:0] d);
        if (k == 0) mq0.push_back(d);
        else if (k == 1) mq1.push_back(d);
        else mq2.push_back(d);
        mlast[k] = d;
    endtask

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        mq2.delete();
        for (int k = 0; k < 3; k++) mlast[k] = 4'h0;
        mdrops = 0;
    endtask

    function automatic logic [3:0] dut_data(input int k);
        if (k == 0) return bus.out1_data;
        if (k == 1) return bus.out2_data;
        return bus.out3_data;
    endfunction

    function automatic logic dut_valid(input int k);
        if (k == 0) return bus.out1_valid;
        if (k == 1) return bus.out2_valid;
        return bus.out3_valid;
    endfunction

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s lane%0d valid", tag, k + 1), {31'd0, dut_valid(k)},
                  {31'd0, (qsize(k) != 0)});
            check($sformatf("%s lane%0d data", tag, k + 1), {28'd0, dut_data(k)},
                  {28'd0, mlast[k]});
        end
        check({tag, " drop_cnt"}, {24'd0, bus.drop_cnt}, mdrops);
    endtask

    // One cycle, entered and left at a falling edge: drive inputs, check the
    // combinational in_ready, advance the model, clock, then check registers.
    task automatic step(input logic v, input logic [1:0] dest, input logic [3:0] d,
                        input logic r1, input logic r2, input logic r3, input string tag);
        logic [2:0] r;
        logic [2:0] fr;
        logic       exp_rdy;
        r = {r3, r2, r1};
        bus.in_valid   = v;
        bus.in_dest    = dest;
        bus.in_data    = d;
        bus.out1_ready = r1;
        bus.out2_ready = r2;
        bus.out3_ready = r3;
        for (int k = 0; k < 3; k++) fr[k] = (qsize(k) == 0) || r[k];
        if (dest < 2'd3) exp_rdy = fr[dest];
`ifdef DEMUX_BCAST_EN
        else exp_rdy = fr[0] && fr[1] && fr[2];
`else
        else exp_rdy = 1'b1;
`endif
        #1;
        check({tag, " in_ready"}, {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        for (int k = 0; k < 3; k++) if (r[k] && qsize(k) != 0) qpop(k);
        if (v && exp_rdy) begin
            if (dest < 2'd3) qpush(int'(dest), d);
            else begin
`ifdef DEMUX_BCAST_EN
                for (int k = 0; k < 3; k++) qpush(k, d);
`else
                if (mdrops < 255) mdrops++;
`endif
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_dest    = 2'd0;
        bus.in_data    = 4'h0;
        bus.out1_ready = 1'b0;
        bus.out2_ready = 1'b0;
        bus.out3_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // Put a word in lane 2 and hold it, then reset asynchronously mid-cycle.
        step(1'b1, 2'd1, 4'h9, 1'b1, 1'b0, 1'b1, "pre_reset");
        check("pre_reset out2_valid", {31'd0, bus.out2_valid}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_dest  = 2'd0;
        bus.in_data  = 4'h3;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 2'd0, 4'hA, 1'b1, 1'b1, 1'b1, "after_reset");
        check("after_reset out1_data", {28'd0, bus.out1_data}, 32'hA);

        // Routing and latency across the three lanes.
        step(1'b1, 2'd0, 4'h1, 1'b1, 1'b1, 1'b1, "route0");
        check("route0 out1_data", {28'd0, bus.out1_data}, 32'h1);
        step(1'b1, 2'd1, 4'h2, 1'b1, 1'b1, 1'b1, "route1");
        check("route1 out2_data", {28'd0, bus.out2_data}, 32'h2);
        step(1'b1, 2'd2, 4'h3, 1'b1, 1'b1, 1'b1, "route2");
        check("route2 out3_data", {28'd0, bus.out3_data}, 32'h3);
        step(1'b0, 2'd0, 4'h0, 1'b1, 1'b1, 1'b1, "idle");

        // Backpressure on lane 3 only.
        step(1'b1, 2'd2, 4'h5, 1'b1, 1'b1, 1'b0, "bp_load5");
        step(1'b1, 2'd2, 4'h6, 1'b1, 1'b1, 1'b0, "bp_block6");
        check("bp_block6 out3_data", {28'd0, bus.out3_data}, 32'h5);
        step(1'b1, 2'd0, 4'h7, 1'b1, 1'b1, 1'b0, "bp_other7");
        check("bp_other7 out1_data", {28'd0, bus.out1_data}, 32'h7);
        step(1'b1, 2'd2, 4'h6, 1'b1, 1'b1, 1'b1, "bp_release6");
        check("bp_release6 out3_data", {28'd0, bus.out3_data}, 32'h6);
        check("bp_release6 out3_valid", {31'd0, bus.out3_valid}, 32'd1);

        // Full rate into lane 2.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 2'd1, 4'(i), 1'b1, 1'b1, 1'b1, "full_rate");
            check($sformatf("full_rate word%0d", i), {28'd0, bus.out2_data}, i);
        end
        step(1'b0, 2'd0, 4'h0, 1'b1, 1'b1, 1'b1, "drain");

`ifdef DEMUX_BCAST_EN
        // Broadcast waits for every lane to be free.
        step(1'b1, 2'd0, 4'h4, 1'b0, 1'b1, 1'b1, "bc_fill1");
        step(1'b1, 2'd3, 4'hC, 1'b0, 1'b1, 1'b1, "bc_block");
        check("bc_block out1_data", {28'd0, bus.out1_data}, 32'h4);
        step(1'b1, 2'd3, 4'hC, 1'b1, 1'b0, 1'b0, "bc_go");
        check("bc_go out1_data", {28'd0, bus.out1_data}, 32'hC);
        check("bc_go out2_data", {28'd0, bus.out2_data}, 32'hC);
        check("bc_go out3_data", {28'd0, bus.out3_data}, 32'hC);
        check("bc_go drop_cnt", {24'd0, bus.drop_cnt}, 32'd0);
        step(1'b0, 2'd0, 4'h0, 1'b1, 1'b1, 1'b1, "bc_drain");
`else
        // Discarded words saturate the counter and never touch a lane.
        for (int i = 0; i < 260; i++) begin
            step(1'b1, 2'd3, 4'(i), 1'b1, 1'b1, 1'b1, "drop");
        end
        check("drop saturated", {24'd0, bus.drop_cnt}, 32'd255);
        check("drop no lane valid",
              {29'd0, bus.out3_valid, bus.out2_valid, bus.out1_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("drop_reset");
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 2) != 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
